// File: rtl/stopwatch_pkg.sv
// ============================================================================
// Module  : stopwatch_pkg
// Brief   : State encoding shared by the stopwatch controller and its bus.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package stopwatch_pkg;

   localparam int unsigned STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_LAP    = 2'b10,
      ST_PAUSED = 2'b11
   } state_t;

endpackage : stopwatch_pkg

`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
// ============================================================================
// Module  : stopwatch_ctrl_if
// Brief   : Button inputs and counter/display control outputs of the stopwatch.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stopwatch_ctrl_if;

   logic                              btn_ss;
   logic                              btn_lr;
   logic                              tick;
   logic                              clr;
   logic                              freeze;
   logic [stopwatch_pkg::STATE_W-1:0] state;

   modport master (
      output btn_ss, btn_lr,
      input  tick, clr, freeze, state
   );

   modport slave (
      input  btn_ss, btn_lr,
      output tick, clr, freeze, state
   );

endinterface : stopwatch_ctrl_if

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// Module  : btn_debounce
// Brief   : 2-FF synchronizer, counting debouncer and rising-edge press pulse.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  wire logic clk,
   input  wire logic rst_n,
   input  wire logic i_btn,
   output logic      o_press
);

   localparam int unsigned          c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [c_CNT_W-1:0]   c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

   logic               r_sync1;
   logic               r_sync2;
   logic [1:0]         r_warm;
   logic               r_armed;
   logic               r_level;
   logic               r_level_d;
   logic [c_CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_warm    <= 2'b00;
         r_armed   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= i_btn;
         r_sync2   <= r_sync1;
         r_warm    <= {r_warm[0], 1'b1};
         r_level_d <= r_level;
         // Presses are only honoured once a genuine released sample has been seen,
         // so a button held through reset release must be let go first.
         if (r_warm[1] && !r_sync2) begin
            r_armed <= 1'b1;
         end
         if (r_sync2 != r_level) begin
            if (r_cnt == c_CNT_LAST) begin
               r_level <= r_sync2;
               r_cnt   <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_press = r_level & ~r_level_d & r_armed;

endmodule : btn_debounce

`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
// ============================================================================
// Module  : stopwatch_ctrl
// Brief   : Stopwatch start/stop/lap/reset FSM with tick prescaler.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned CLK_DIV         = 100,
   parameter int unsigned DEBOUNCE_CYCLES = 4
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   stopwatch_ctrl_if.slave  bus
);

   localparam int unsigned        c_PS_W    = $clog2(CLK_DIV);
   localparam logic [c_PS_W-1:0]  c_PS_LAST = c_PS_W'(CLK_DIV - 1);

   logic              w_press_ss;
   logic              w_press_lr;
   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_clr_nxt;
   logic              w_running;
   logic              w_wrap;
   logic [c_PS_W-1:0] r_ps;
   logic              r_tick;
   logic              r_clr;
   logic              r_freeze;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_ss (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (bus.btn_ss),
      .o_press (w_press_ss)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_lr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (bus.btn_lr),
      .o_press (w_press_lr)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Start/stop has priority: a simultaneous lap/reset press is dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_clr_nxt   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_press_ss) begin
               w_state_nxt = ST_RUN;
            end else if (w_press_lr) begin
               w_clr_nxt = 1'b1;
            end
         end
         ST_RUN: begin
            if (w_press_ss) begin
               w_state_nxt = ST_PAUSED;
            end else if (w_press_lr) begin
               w_state_nxt = ST_LAP;
            end
         end
         ST_LAP: begin
            if (w_press_ss) begin
               w_state_nxt = ST_PAUSED;
            end else if (w_press_lr) begin
               w_state_nxt = ST_RUN;
            end
         end
         ST_PAUSED: begin
            if (w_press_ss) begin
               w_state_nxt = ST_RUN;
            end else if (w_press_lr) begin
               w_state_nxt = ST_IDLE;
               w_clr_nxt   = 1'b1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign w_running = (r_state == ST_RUN) || (r_state == ST_LAP);
   assign w_wrap    = w_running && (r_ps == c_PS_LAST);

   // Prescaler advances on the pre-transition state so a wrap racing a pause still ticks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ps     <= '0;
         r_tick   <= 1'b0;
         r_clr    <= 1'b0;
         r_freeze <= 1'b0;
      end else begin
         if (w_state_nxt == ST_IDLE) begin
            r_ps <= '0;
         end else if (w_running) begin
            r_ps <= w_wrap ? '0 : r_ps + 1'b1;
         end
         r_tick   <= w_wrap;
         r_clr    <= w_clr_nxt;
         r_freeze <= (w_state_nxt == ST_LAP);
      end
   end

   assign bus.tick   = r_tick;
   assign bus.clr    = r_clr;
   assign bus.freeze = r_freeze;
   assign bus.state  = r_state;

endmodule : stopwatch_ctrl

`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
// ============================================================================
// Module  : tb_stopwatch_ctrl
// Brief   : Directed self-checking bench for stopwatch_ctrl (CLK_DIV=100, DEBOUNCE=4).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   int   tick_cnt = 0;
   int   clr_cnt = 0;
   int   overlap_cnt = 0;

   stopwatch_ctrl_if u_if ();

   stopwatch_ctrl #(
      .CLK_DIV         (100),
      .DEBOUNCE_CYCLES (4)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (u_if.tick) tick_cnt++;
      if (u_if.clr) clr_cnt++;
      if (u_if.tick && u_if.clr) overlap_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Drive buttons for 20 cycles from the current falling edge and note when state moves.
   task automatic push(input logic ss, input logic lr, output int entry, output int lat);
      logic [1:0] prior;
      int         start;
      prior = u_if.state;
      start = cyc;
      entry = -1;
      lat   = -1;
      u_if.btn_ss = ss;
      u_if.btn_lr = lr;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (entry < 0 && u_if.state !== prior) begin
            entry = cyc;
            lat   = cyc - start;
         end
      end
      u_if.btn_ss = 1'b0;
      u_if.btn_lr = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic wait_tick(input int budget, output int c);
      c = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (u_if.tick) begin
            c = cyc;
            break;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int entry, lat, t1, t2, t3, t4, p_entry, r_entry, held, tk0, clr0;
      u_if.btn_ss = 1'b0;
      u_if.btn_lr = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state",  32'(u_if.state),  0);
      check("rst_tick",   32'(u_if.tick),   0);
      check("rst_clr",    32'(u_if.clr),    0);
      check("rst_freeze", 32'(u_if.freeze), 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Start: press latency and tick cadence
      push(1'b1, 1'b0, entry, lat);
      check("start_state", 32'(u_if.state), 1);
      check("start_lat_in_6_8", 32'((lat >= 6) && (lat <= 8)), 1);
      wait_tick(150, t1);
      check("first_tick_delay", 32'(t1 - entry), 100);
      wait_tick(150, t2);
      check("second_tick_period", 32'(t2 - t1), 100);

      // 3-cycle glitch must not register
      u_if.btn_ss = 1'b1;
      repeat (3) @(negedge clk);
      u_if.btn_ss = 1'b0;
      wait_tick(150, t3);
      check("glitch_tick_period", 32'(t3 - t2), 100);
      check("glitch_state", 32'(u_if.state), 1);

      // Pause near prescaler 40, sit 500 cycles, resume
      repeat (33) @(negedge clk);
      push(1'b1, 1'b0, p_entry, lat);
      check("pause_state", 32'(u_if.state), 3);
      held = p_entry - t3;
      check("pause_point_near_40", 32'((held >= 39) && (held <= 41)), 1);
      tk0 = tick_cnt;
      repeat (500) @(negedge clk);
      check("pause_no_ticks", 32'(tick_cnt), 32'(tk0));
      check("pause_state_hold", 32'(u_if.state), 3);
      push(1'b1, 1'b0, r_entry, lat);
      check("resume_state", 32'(u_if.state), 1);
      wait_tick(150, t4);
      check("resume_partial", 32'(t4 - r_entry), 32'(100 - held));

      // Lap and back
      push(1'b0, 1'b1, entry, lat);
      check("lap_state", 32'(u_if.state), 2);
      check("lap_freeze", 32'(u_if.freeze), 1);
      wait_tick(110, t1);
      check("lap_tick_runs", 32'(t1 != -1), 1);
      push(1'b0, 1'b1, entry, lat);
      check("unlap_state", 32'(u_if.state), 1);
      check("unlap_freeze", 32'(u_if.freeze), 0);

      // Pause, reset to idle, clear again in idle
      push(1'b1, 1'b0, entry, lat);
      check("pause2_state", 32'(u_if.state), 3);
      clr0 = clr_cnt;
      push(1'b0, 1'b1, entry, lat);
      check("reset_state", 32'(u_if.state), 0);
      check("reset_clr_once", 32'(clr_cnt - clr0), 1);
      push(1'b0, 1'b1, entry, lat);
      check("idle_lr_state", 32'(u_if.state), 0);
      check("idle_lr_clr", 32'(clr_cnt - clr0), 2);
      push(1'b1, 1'b0, entry, lat);
      wait_tick(150, t1);
      check("restart_from_zero", 32'(t1 - entry), 100);

      // Simultaneous ss+lr: ss wins, no clear
      clr0 = clr_cnt;
      push(1'b1, 1'b1, entry, lat);
      check("both_state", 32'(u_if.state), 3);
      check("both_no_clr", 32'(clr_cnt), 32'(clr0));
      push(1'b1, 1'b0, entry, lat);
      check("both_resume", 32'(u_if.state), 1);

      // Asynchronous reset while tick is high
      wait_tick(150, t1);
      check("pre_reset_tick", 32'(u_if.tick), 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_tick",   32'(u_if.tick),   0);
      check("async_rst_state",  32'(u_if.state),  0);
      check("async_rst_clr",    32'(u_if.clr),    0);
      check("async_rst_freeze", 32'(u_if.freeze), 0);
      check("async_rst_no_clr", 32'(clr_cnt), 32'(clr0));

      // Button held across reset release must not start the watch
      u_if.btn_ss = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      check("held_thru_reset", 32'(u_if.state), 0);
      u_if.btn_ss = 1'b0;
      repeat (15) @(negedge clk);
      push(1'b1, 1'b0, entry, lat);
      check("repress_after_release", 32'(u_if.state), 1);

      check("clr_tick_overlap", 32'(overlap_cnt), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_stopwatch_ctrl

`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 100, clk cycles per count tick (range 2..2^16).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 4, consecutive stable cycles required to accept a button level (range 1..255).
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port btn_ss  input  1  raw start/stop button, asynchronous to clk.
REQ-006 SHALL have port btn_lr  input  1  raw lap/reset button, asynchronous to clk.
REQ-007 SHALL have port tick  output  1  one-cycle count-enable pulse to the BCD time counter.
REQ-008 SHALL have port clr  output  1  one-cycle synchronous clear pulse to the BCD time counter.
REQ-009 SHALL have port freeze  output  1  level; display mux holds last shown digits while high.
REQ-010 SHALL have port state  output  2  current FSM state code.

Function
REQ-011 Each button SHALL pass through a 2-FF synchronizer, then a debouncer updating its debounced level only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
REQ-012 A press SHALL be a one-cycle pulse on the debounced level's 0->1 transition; releases generate no event.
REQ-013 A raw press held stable SHALL change state between DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+4 cycles after the raw rising edge.
REQ-014 Glitches shorter than DEBOUNCE_CYCLES cycles SHALL produce no press.
REQ-015 FSM states SHALL be IDLE=00, RUN=01, LAP=10, PAUSED=11.
REQ-016 IDLE: ss -> RUN; lr -> stay IDLE with clr pulse.
REQ-017 RUN: ss -> PAUSED; lr -> LAP.
REQ-018 LAP: ss -> PAUSED; lr -> RUN.
REQ-019 PAUSED: ss -> RUN; lr -> IDLE with clr pulse.
REQ-020 ss and lr presses in the same cycle: ss SHALL take effect, lr SHALL be discarded (no clr).
REQ-021 Prescaler SHALL count 0..CLK_DIV-1 in RUN and LAP, hold its value in PAUSED, and be 0 in IDLE.
REQ-022 On an edge where current state is RUN or LAP and prescaler = CLK_DIV-1, prescaler SHALL wrap to 0 and tick SHALL be 1 for the following cycle; otherwise tick SHALL be 0.
REQ-023 Prescaler advance SHALL use the pre-transition state; a wrap coinciding with a RUN->PAUSED transition still issues its tick.
REQ-024 Resuming PAUSED->RUN SHALL continue from the held prescaler value (no lost or extra partial period).
REQ-025 tick SHALL keep running in LAP; freeze SHALL be 1 exactly while state = LAP.
REQ-026 clr SHALL be registered, asserted the cycle after the edge entering (or remaining in) IDLE by lr, and never coincide with tick.
REQ-027 All outputs SHALL be registered; no combinational path from btn_* to any output.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE, tick=0, clr=0, freeze=0, prescaler=0, synchronizers and debounced levels=0, debounce counters=0.
REQ-029 A button held through reset release SHALL not produce a press until released and pressed again.
REQ-030 Reset asserted mid-RUN SHALL drop tick within the same cycle asynchronously and SHALL not emit clr.

Structure
REQ-031 Package stopwatch_pkg SHALL hold the state encoding constants and the state width (2); CLK_DIV/DEBOUNCE_CYCLES stay module parameters.
REQ-032 Synchronizer+debouncer+edge detect SHALL be sub-module btn_debounce, instantiated twice (ss, lr), parameterised by DEBOUNCE_CYCLES.
REQ-033 Prescaler width SHALL be $clog2(CLK_DIV); debounce counter width $clog2(DEBOUNCE_CYCLES+1).

Verification (CLK_DIV=100, DEBOUNCE_CYCLES=4)
REQ-034 Reset, press ss for 20 cycles -> state=01 within 6-8 cycles; first tick 100 cycles after entry, then every 100 cycles.
REQ-035 RUN, 3-cycle ss glitch -> no state change, tick cadence unbroken.
REQ-036 RUN, ss after prescaler reaches 40, wait 500 cycles, ss again -> no ticks while PAUSED; next tick 60 cycles after re-entering RUN.
REQ-037 RUN, lr -> state=10, freeze=1, ticks continue; lr again -> state=01, freeze=0.
REQ-038 PAUSED, lr -> state=00, exactly one clr pulse, prescaler=0; IDLE lr -> one more clr, state stays 00.
REQ-039 RUN, ss and lr rising on the same clk edge -> state=11, clr never asserted; rst_n low mid-RUN -> all outputs 0 same cycle.
